// File: rtl/serial_word_tx.sv
// Parallel-in, serial-out word transmitter with complementary data line and frame markers.
// Latency: first bit on sout in the cycle after the accept edge; WIDTH consecutive bit cycles.
// Backpressure: din_ready is high in IDLE and in the last-bit cycle only, so frames can run back to back.
module serial_word_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_bar,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             done,
  output logic             busy
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             sout_q, sout_d;

  logic             last_bit;
  logic             accept;
  logic [WIDTH-1:0] shreg_next;

  // Bit that goes out first from a given shift-register image.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Advance the shift register by one position toward the output end.
  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // Handshake and frame flags all derive from registered state only.
  assign last_bit    = (state_q == SHIFT) && (cnt_q == LAST);
  assign din_ready   = (state_q == IDLE) || last_bit;
  assign accept      = din_valid && din_ready;
  assign busy        = (state_q == SHIFT);
  assign sout_valid  = (state_q == SHIFT);
  assign frame_start = (state_q == SHIFT) && (cnt_q == '0);
  assign done        = last_bit;
  assign sout        = sout_q;
  assign sout_bar    = ~sout_q;
  assign shreg_next  = shift_once(shreg_q);

  // Next-state: load on accept, otherwise step through bits, then fall back to idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    sout_d  = sout_q;
    if (accept) begin
      // Covers both a fresh frame from IDLE and a back-to-back reload in the last-bit cycle.
      state_d = SHIFT;
      cnt_d   = '0;
      shreg_d = din;
      sout_d  = first_bit(din);
    end else begin
      unique case (state_q)
        IDLE: begin
          sout_d = 1'b0;
        end
        SHIFT: begin
          if (cnt_q == LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            shreg_d = '0;
            sout_d  = 1'b0;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            shreg_d = shreg_next;
            sout_d  = first_bit(shreg_next);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          shreg_d = '0;
          sout_d  = 1'b0;
        end
      endcase
    end
  end

  // State registers; reset wins over a same-edge accept and drops any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      sout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      sout_q  <= sout_d;
    end
  end

endmodule

// File: doc/serial_word_tx.md
Name: serial_word_tx

Overview:
- Parallel-in, serial-out bit transmitter.
- Accepts a WIDTH-bit operand word through a valid/ready handshake and drives it out one bit per clock.
- Each output bit comes with a complementary line, a valid strobe, and frame markers.
- It is the sending end of the single-bit registered data path (D, Q/Qbar) used in the adder datapath, so operands can be streamed serially into flip-flop-based capture stages.

Parameters:
- WIDTH, 4, bits per word; must be >= 2.
- MSB_FIRST, 0, bit order: 0 sends bit 0 first; 1 sends bit WIDTH-1 first.

Ports:
- clk  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- din  input  WIDTH  parallel word; sampled only on an accept edge.
- din_valid  input  1  producer has a word on din.
- din_ready  output  1  block can accept a word this cycle.
- sout  output  1  serial data bit (registered).
- sout_bar  output  1  always equal to ~sout.
- sout_valid  output  1  sout carries a frame bit this cycle.
- frame_start  output  1  high only during the first bit of a frame.
- done  output  1  high only during the last bit of a frame.
- busy  output  1  high while a frame is being sent.

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high (reset), evaluated at the rising edge of clk.
- Reset values:
  - sout=0, sout_bar=1
  - sout_valid=0, frame_start=0, done=0, busy=0
  - din_ready=1
  - state IDLE, bit counter 0, shift register 0.
- States: IDLE, SHIFT.
- Accept: an edge where din_valid=1 and din_ready=1. At that edge:
  - din is loaded into the shift register.
  - The first bit is registered onto sout.
  - sout_valid=1, frame_start=1, busy=1, counter=0.
  - State goes to SHIFT.
- Latency: the first bit appears in the cycle right after the accept edge.
- SHIFT: each edge advances to the next bit in the order set by MSB_FIRST.
  - Bits are presented in cycles 1..WIDTH after the accept edge, one bit per cycle, with sout_valid=1 throughout.
  - frame_start is high in cycle 1 only.
  - done is high in cycle WIDTH only, concurrent with the last bit.
- din_ready (combinational from registered state) is 1 in IDLE, and 1 in SHIFT only when the counter equals WIDTH-1 (the last-bit cycle). Otherwise it is 0.
- Back-to-back frames: if an accept occurs at the end of the last-bit cycle, the next word's first bit is presented in the very next cycle.
  - No idle gap between frames.
  - frame_start reasserts and busy stays 1.
- End of frame with no accept: the next edge returns to IDLE with sout=0, sout_valid=0, busy=0, done=0. sout_bar tracks sout.
- din_valid while din_ready=0: ignored. din is not sampled and the stream in flight is unaffected.
- Reset mid-frame: the frame is aborted and the word discarded. On the next edge all outputs take their reset values, and no done pulse is produced for the aborted frame.
- reset takes priority over a simultaneous accept.
- Counter width: clog2(WIDTH). No wrap-around past WIDTH-1. The counter is cleared on every accept.
- sout_bar is never equal to sout in any cycle, including during reset.

Test Plan:
- Reset: hold reset 2 cycles with din_valid=1, din=4'hF -> sout=0, sout_bar=1, sout_valid=0, busy=0, din_ready=1; no frame starts.
- Single word, WIDTH=4, MSB_FIRST=0, din=4'b1011 accepted at edge 0 -> cycles 1..4 carry sout=1,1,0,1 with sout_bar=0,0,1,0. frame_start only in cycle 1, done only in cycle 4, sout_valid=0 and busy=0 in cycle 5.
- MSB_FIRST=1, din=4'b1011 -> sout=1,0,1,1 over cycles 1..4, with the same frame_start and done timing.
- Back-to-back, din_valid held high with 4'hA then 4'h5 (LSB first) -> 8 consecutive valid cycles with sout=0,1,0,1,1,0,1,0. frame_start in cycles 1 and 5, done in cycles 4 and 8, din_ready high only in cycles 4 and 8 (and in IDLE).
- Ignored input: in cycle 2 of a 4'b1011 frame, pulse din_valid=1 with din=4'h0 -> din_ready=0, the stream still reads 1,1,0,1, and no extra frame is sent.
- Mid-frame reset: assert reset during cycle 2 of a frame -> next cycle shows the reset outputs and no done. Then send 4'b0110 -> cycles 1..4 carry sout=0,1,1,0 cleanly.
